// File: rtl/strobe_checker.sv
// Strobe period checker: measures the cycle interval between strobe rising edges,
// flags early/late strobes, declares lock after a run of good intervals.
module strobe_checker #(
  parameter int CLOCK_HZ   = 10_000_000,
  parameter int PERIOD_NS  = 100_000,
  parameter int TOLERANCE  = 2,
  parameter int LOCK_COUNT = 4,
  localparam int NOMINAL   = $rtoi(real'(CLOCK_HZ) * real'(PERIOD_NS) / 1.0e9),
  localparam int MIN_CYC   = NOMINAL - TOLERANCE,
  localparam int MAX_CYC   = NOMINAL + TOLERANCE,
  localparam int WIDTH     = $clog2(MAX_CYC + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable_i,
  input  logic             Strobe_i,
  output logic [WIDTH-1:0] Period_o,
  output logic             PeriodValid_o,
  output logic             Early_o,
  output logic             Late_o,
  output logic             Locked_o,
  output logic [7:0]       ErrorCount_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_CYC);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_CYC);
  localparam logic [GW-1:0]    LOCK_G = GW'(LOCK_COUNT);

  if (MIN_CYC < 2 || TOLERANCE < 0 || LOCK_COUNT < 1) begin : g_param_check
    $fatal(1, "strobe_checker: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ARM, TRACK} state_e;

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic             event_q, event_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [GW-1:0]    good_q, good_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             locked_q, locked_d;
  logic [7:0]       err_q, err_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: every signal gets its default first, so no path through the case leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    good_d    = good_q;
    period_d  = period_q;
    locked_d  = locked_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    early_d   = 1'b0;
    late_d    = 1'b0;
    prev_d    = Strobe_i;
    event_d   = Strobe_i & ~prev_q;

    if (!Enable_i) begin
      state_d   = IDLE;
      counter_d = '0;
      good_d    = '0;
      locked_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (event_q) begin
            counter_d = WIDTH'(1);
            state_d   = TRACK;
          end
        end
        TRACK: begin
          // An event coinciding with the timeout wins: that interval equals MAX.
          if (event_q) begin
            period_d  = counter_q;
            valid_d   = 1'b1;
            counter_d = WIDTH'(1);
            if (counter_q < MIN_W) begin
              early_d  = 1'b1;
              err_d    = sat_inc(err_q);
              good_d   = '0;
              locked_d = 1'b0;
            end else begin
              good_d   = (good_q == LOCK_G) ? good_q : good_q + 1'b1;
              locked_d = (good_d == LOCK_G);
            end
          end else if (counter_q == MAX_W) begin
            late_d    = 1'b1;
            err_d     = sat_inc(err_q);
            good_d    = '0;
            locked_d  = 1'b0;
            counter_d = '0;
            state_d   = ARM;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      prev_q    <= 1'b0;
      event_q   <= 1'b0;
      counter_q <= '0;
      good_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      event_q   <= event_d;
      counter_q <= counter_d;
      good_q    <= good_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      early_q   <= early_d;
      late_q    <= late_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign Period_o      = period_q;
  assign PeriodValid_o = valid_q;
  assign Early_o       = early_q;
  assign Late_o        = late_q;
  assign Locked_o      = locked_q;
  assign ErrorCount_o  = err_q;

endmodule

// File: doc/strobe_checker.md
# strobe_checker

Receive-side companion to the periodic strobe generator: samples a strobe line, measures the clock-cycle interval between strobes, and checks it against a nominal period derived from `CLOCK_HZ` and `PERIOD_NS`. It reports each measured period, flags early strobes and missing (late) strobes, declares lock after a run of good intervals, and keeps a saturating error count. It sits beside any strobe consumer (sampling ticks, scan timers) as a health monitor.

## Interface
- `CLOCK_HZ`, 10_000_000, system clock frequency in Hz.
- `PERIOD_NS`, 100_000, expected strobe period in ns.
- `TOLERANCE`, 2, allowed deviation in cycles.
- `LOCK_COUNT`, 4, consecutive good intervals required for lock.
- `Clock`  input  1  system clock, rising edge.
- `Reset`  input  1  synchronous, active-low reset.
- `Enable_i`  input  1  checker enable.
- `Strobe_i`  input  1  strobe under test, synchronous to `Clock`.
- `Period_o`  output  WIDTH  last measured interval in cycles.
- `PeriodValid_o`  output  1  one-cycle pulse when `Period_o` updates.
- `Early_o`  output  1  one-cycle pulse: interval below `NOMINAL-TOLERANCE`.
- `Late_o`  output  1  one-cycle pulse: no strobe within `MAX` cycles.
- `Locked_o`  output  1  level, stable period confirmed.
- `ErrorCount_o`  output  8  saturating count of Early/Late events.

## Operation
- Derived constants:
  - `NOMINAL = $rtoi(CLOCK_HZ*PERIOD_NS/1e9)`, computed in real arithmetic and truncated.
  - `MIN = NOMINAL-TOLERANCE`.
  - `MAX = NOMINAL+TOLERANCE`.
  - `WIDTH = $clog2(MAX+1)`.
  - `$fatal` at elaboration if `MIN < 2`, `TOLERANCE < 0`, or `LOCK_COUNT < 1`.
- Event detection: `Event = Strobe_i & ~Prev`. `Prev` is registered every cycle regardless of state. A held-high strobe yields one event.
- States:
  - IDLE: entered from any state when `Enable_i` is low; also the state after reset. Moves to ARM on the first cycle `Enable_i` is high. An event in that same cycle is ignored.
  - ARM: waiting for the first event. On event, load Counter = 1 and go to TRACK. No measurement is produced.
  - TRACK, event: measured = Counter; `Period_o` <= measured; `PeriodValid_o` pulses; Counter reloads 1.
    - If measured < MIN: `Early_o` pulses, the error is counted, GoodRun = 0, `Locked_o` = 0, and the checker stays in TRACK.
    - Else (MIN..MAX): the interval is good. GoodRun increments, saturating at `LOCK_COUNT`. `Locked_o` is set when GoodRun reaches `LOCK_COUNT`.
  - TRACK, no event, Counter == MAX: `Late_o` pulses, the error is counted, GoodRun = 0, `Locked_o` = 0, and the checker goes to ARM. `Period_o` is unchanged and there is no `PeriodValid_o`.
  - TRACK, no event, Counter < MAX: Counter increments.
- Event and timeout in the same cycle (event with Counter == MAX): the event wins and the interval is good.
- `ErrorCount_o` increments by one per error and saturates at 255. Only reset clears it.
- `Enable_i` low: the next edge gives IDLE, Counter = 0, GoodRun = 0, `Locked_o` = 0, and all pulses 0. `Period_o` and `ErrorCount_o` are retained.

## Timing
- All outputs are registered.
- An event sampled at edge t produces `Period_o`, `PeriodValid_o`, `Early_o` and `Locked_o` changes visible after edge t+1.
- For strobes sampled at edges t and t+N, the measured value is N.
- Timeout: with the last event at edge t and no further event, Counter == MAX is sampled at edge t+MAX. `Late_o` is high for exactly one cycle after edge t+MAX+1.
- Pulses never last longer than one cycle. `Early_o` and `Late_o` are mutually exclusive.
- Reset is sampled only at the rising edge; a low pulse between edges has no effect.
- Reset values: state IDLE; `Period_o` 0, `PeriodValid_o` 0, `Early_o` 0, `Late_o` 0, `Locked_o` 0, `ErrorCount_o` 0; internal `Prev` 0, Counter 0, GoodRun 0.
- Reset asserted mid-TRACK aborts immediately with no pulse emitted.

## Test plan
All scenarios use defaults: NOMINAL = 1000, MIN = 998, MAX = 1002.
- Enable high, one-cycle strobes every 1000 cycles: strobe 1 gives no `PeriodValid_o`. Strobes 2–5 each give a `PeriodValid_o` pulse with `Period_o` = 1000. `Locked_o` rises 1 cycle after strobe 5 is sampled. `ErrorCount_o` stays 0.
- Once locked, interval 997: `Early_o` pulse, `Period_o` = 997, `Locked_o` = 0, `ErrorCount_o` = 1. Intervals 998 and 1002 are then accepted with no error.
- Once locked, strobe withheld: `Late_o` is a single pulse after edge t+1003, `Locked_o` = 0, ARM is entered. The next strobe gives no `PeriodValid_o`; the one after that measures normally.
- `Strobe_i` held high for 50 cycles, then period 1000 from its rising edge: exactly one event per rising edge, measured 1000, no `Early_o`.
- `Enable_i` dropped mid-TRACK for 10 cycles: `Locked_o` = 0, no pulses, `Period_o` and `ErrorCount_o` retained. After re-enable, the first strobe only arms.
- 300 consecutive intervals of 500: `ErrorCount_o` saturates at 255. Synchronous `Reset` low for one edge returns all outputs to 0.
